// File: rtl/regfile_pkg.sv
// Shared types and the byte-merge helper for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  // Widest data word the merge helper handles; callers cast to/from their XLEN.
  localparam int unsigned MERGE_W  = 256;
  localparam int unsigned MERGE_BW = MERGE_W / 8;

  // Byte-granular merge: enabled bytes come from new_val, the rest from old_val.
  function automatic logic [MERGE_W-1:0] merge_be(input logic [MERGE_W-1:0]  old_val,
                                                  input logic [MERGE_W-1:0]  new_val,
                                                  input logic [MERGE_BW-1:0] be);
    logic [MERGE_W-1:0] res_val;
    res_val = old_val;
    for (int i = 0; i < int'(MERGE_BW); i++) begin
      if (be[i]) res_val[8*i +: 8] = new_val[8*i +: 8];
    end
    return res_val;
  endfunction

endpackage

// File: rtl/regfile_clr_fsm.sv
// Sequential clear engine: walks every entry writing zero after reset or a clear request.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr_req,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  // State register; reset always restarts the pass from entry 0.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= RF_CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    clr_we  = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          idx_d   = '0;
        end
      end
      RF_CLEAR: begin
        clr_we = !res;
        if (idx_q == LAST_IDX) begin
          state_d = RF_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  assign busy    = (state_q == RF_CLEAR);
  assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with byte enables and a clear engine.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 2,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                res,
  input  logic                clr_req,
  output logic                busy,
  output logic                wr_ready,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN/8-1:0]   wr_be,
  input  logic [XLEN-1:0]     wr_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0] mem [NREGS];
  logic            clr_we;
  logic [AW-1:0]   clr_idx;
  logic            wr_acc_c;
  logic [XLEN-1:0] wr_merged_c;

  regfile_clr_fsm #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_clr_fsm (
    .clk     (clk),
    .res     (res),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign wr_ready = !busy;

  // Accepted write: port ready, in range, not the hardwired-zero entry, not under reset.
  assign wr_acc_c = wr_en && wr_ready && !res
                  && ({1'b0, wr_addr} < NREGS_W)
                  && !((ZERO_REG != 0) && (wr_addr == '0));

  assign wr_merged_c = XLEN'(merge_be(MERGE_W'(mem[wr_addr]), MERGE_W'(wr_data),
                                      MERGE_BW'(wr_be)));

  // Clear and write never coincide: writes need !busy, clear only runs while busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc_c) begin
      mem[wr_addr] <= wr_merged_c;
    end
  end

  for (genvar k = 0; k < int'(NRD); k++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;

    assign ra = rd_addr[k*AW +: AW];

    always_comb begin
      val = mem[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_acc_c && (wr_addr == ra)) val = wr_merged_c;
`else
`endif
      if (busy || !({1'b0, ra} < NREGS_W) || ((ZERO_REG != 0) && (ra == '0))) val = '0;
    end

    assign rd_data[k*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (32-entry 4-port instance plus a 24-entry instance).
module tb_regfile_mp;

  logic         clk = 1'b0;
  logic         res;
  logic         clr_req;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [3:0]   wr_be;
  logic [31:0]  wr_data;
  logic         busy, wr_ready;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data;
  logic         busy_s, wr_ready_s;
  logic [4:0]   rd_addr_s;
  logic [31:0]  rd_data_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .ZERO_REG(1)) dut (
    .clk(clk), .res(res), .clr_req(clr_req), .busy(busy), .wr_ready(wr_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  regfile_mp #(.XLEN(32), .NREGS(24), .NRD(1), .ZERO_REG(1)) dut_s (
    .clk(clk), .res(res), .clr_req(clr_req), .busy(busy_s), .wr_ready(wr_ready_s),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .rd_addr(rd_addr_s), .rd_data(rd_data_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    res = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;
    checks++;
    if ({busy, wr_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_busy: busy,wr_ready=%b expected 10", {busy, wr_ready});
    end
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL reset_len: busy cycles %0d expected 32", n);
    end
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: wr_ready=%b expected 1", wr_ready);
    end
    checks++;
    if (busy_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_small: busy_s=%b expected 0", busy_s);
    end
    for (int a = 0; a < 32; a++) begin
      rd_addr[(a % 4)*5 +: 5] = 5'(a);
      #1;
      checks++;
      if (rd_data[(a % 4)*32 +: 32] !== 32'h0) begin
        errors++;
        $display("FAIL reset_zero: addr %0d got %h expected 00000000", a, rd_data[(a % 4)*32 +: 32]);
      end
    end
  endtask

  task automatic test_byte_write();
    do_write(5'd5, 32'hAABBCCDD, 4'hF);
    rd_addr[4:0] = 5'd5;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL byte_full: got %h expected aabbccdd", rd_data[31:0]);
    end
    do_write(5'd5, 32'h11223344, 4'b0101);
    checks++;
    if (rd_data[31:0] !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL byte_partial: got %h expected aa22cc44", rd_data[31:0]);
    end
    do_write(5'd5, 32'hFFFFFFFF, 4'b0000);
    checks++;
    if (rd_data[31:0] !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL byte_noop: got %h expected aa22cc44", rd_data[31:0]);
    end
  endtask

  task automatic test_zero_range();
    do_write(5'd0, 32'hDEADBEEF, 4'hF);
    rd_addr[4:0] = 5'd0;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL zero_reg: got %h expected 00000000", rd_data[31:0]);
    end
    do_write(5'd30, 32'h30303030, 4'hF);
    rd_addr_s = 5'd30;
    rd_addr[9:5] = 5'd30;
    #1;
    checks++;
    if (rd_data_s !== 32'h0) begin
      errors++;
      $display("FAIL range_drop: got %h expected 00000000", rd_data_s);
    end
    checks++;
    if (rd_data[63:32] !== 32'h30303030) begin
      errors++;
      $display("FAIL range_big: got %h expected 30303030", rd_data[63:32]);
    end
    do_write(5'd23, 32'h23232323, 4'hF);
    rd_addr_s = 5'd23;
    #1;
    checks++;
    if (rd_data_s !== 32'h23232323) begin
      errors++;
      $display("FAIL range_last: got %h expected 23232323", rd_data_s);
    end
  endtask

  task automatic test_multiport();
    do_write(5'd9, 32'h55, 4'hF);
    rd_addr = {5'd0, 5'd9, 5'd9, 5'd9};
    #1;
    checks++;
    if (rd_data !== {32'h0, 32'h55, 32'h55, 32'h55}) begin
      errors++;
      $display("FAIL multiport: got %h expected 0 55 55 55", rd_data);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_same;
    do_write(5'd3, 32'h1, 4'hF);
    rd_addr[4:0] = 5'd3;
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h2;
    wr_be   = 4'hF;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h2;
`else
    exp_same = 32'h1;
`endif
    checks++;
    if (rd_data[31:0] !== exp_same) begin
      errors++;
      $display("FAIL bypass_same: got %h expected %h", rd_data[31:0], exp_same);
    end
    tick();
    wr_en = 1'b0;
    checks++;
    if (rd_data[31:0] !== 32'h2) begin
      errors++;
      $display("FAIL bypass_next: got %h expected 00000002", rd_data[31:0]);
    end
  endtask

  task automatic test_mid_clear();
    int n;
    do_write(5'd7, 32'h1234, 4'hF);
    rd_addr[4:0] = 5'd7;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h1234) begin
      errors++;
      $display("FAIL mid_pre: got %h expected 00001234", rd_data[31:0]);
    end
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b1 || rd_data[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL mid_busy: busy=%b data=%h expected 1 00000000", busy, rd_data[31:0]);
    end
    res = 1'b1;
    tick();
    res = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h77;
    wr_be   = 4'hF;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      clr_req = (n == 5);
      tick();
      n++;
      if (busy !== 1'b1) wr_en = 1'b0;
    end
    wr_en   = 1'b0;
    clr_req = 1'b0;
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL mid_restart: busy cycles %0d expected 32", n);
    end
    rd_addr[9:5] = 5'd5;
    #1;
    checks++;
    if (rd_data[31:0] !== 32'h0 || rd_data[63:32] !== 32'h0) begin
      errors++;
      $display("FAIL mid_cleared: r7=%h r5=%h expected 0 0", rd_data[31:0], rd_data[63:32]);
    end
  endtask

  initial begin
    res       = 1'b1;
    clr_req   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_be     = '0;
    wr_data   = '0;
    rd_addr   = '0;
    rd_addr_s = '0;
    test_reset();
    test_byte_write();
    test_zero_range();
    test_multiport();
    test_bypass();
    test_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
